// File: rtl/ldm_addr_seq.sv
// Execute-stage address sequencer for load/store-multiple: one word address and
// register index per transfer, then a one-cycle base writeback strobe.
//   state | meaning
//   IDLE  | waiting for start with a non-empty register list
//   XFER  | emitting transfers, one per advance handshake
module ldm_addr_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] reglist,
    input  logic [31:0] base,
    input  logic [3:0]  rn,
    input  logic        p_bit,
    input  logic        u_bit,
    input  logic        w_bit,
    input  logic        load,
    input  logic        advance,
    input  logic        FlushE,
    output logic [31:0] addr,
    output logic [3:0]  reg_idx,
    output logic        valid,
    output logic        last,
    output logic        busy,
    output logic        wb_en,
    output logic [31:0] wb_value
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  reg_idx_q, reg_idx_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        wb_en_q, wb_en_d;
    logic [31:0] wb_value_q, wb_value_d;
    logic        wb_qual_q, wb_qual_d;

    logic [4:0]  n_cnt;
    logic [31:0] four_n;
    logic [15:0] rem_next;
    logic [31:0] first_addr;

    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        lowest_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_idx = 4'(i);
        end
    endfunction

    function automatic logic [4:0] popcnt(input logic [15:0] v);
        popcnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            popcnt = popcnt + 5'(v[i]);
        end
    endfunction

    function automatic logic is_onehot(input logic [15:0] v);
        is_onehot = (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    always_comb begin
        n_cnt    = popcnt(reglist);
        four_n   = {25'd0, n_cnt, 2'b00};
        rem_next = rem_q & ~(16'd1 << reg_idx_q);
        unique case ({p_bit, u_bit})
            2'b01:   first_addr = base;
            2'b11:   first_addr = base + 32'd4;
            2'b00:   first_addr = base - four_n + 32'd4;
            default: first_addr = base - four_n;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        reg_idx_d  = reg_idx_q;
        valid_d    = valid_q;
        last_d     = last_q;
        wb_en_d    = 1'b0;
        wb_value_d = wb_value_q;
        wb_qual_d  = wb_qual_q;

        if (FlushE) begin
            state_d = IDLE;
            rem_d   = 16'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && (reglist != 16'd0)) begin
                        state_d    = XFER;
                        rem_d      = reglist;
                        addr_d     = first_addr;
                        reg_idx_d  = lowest_idx(reglist);
                        valid_d    = 1'b1;
                        last_d     = is_onehot(reglist);
                        wb_value_d = u_bit ? (base + four_n) : (base - four_n);
                        // LDM that reloads the base register wins over writeback
                        wb_qual_d  = w_bit & ~(load & reglist[rn]);
                    end
                end
                XFER: begin
                    if (advance) begin
                        rem_d  = rem_next;
                        addr_d = addr_q + 32'd4;
                        if (last_q) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            wb_en_d = wb_qual_q;
                        end else begin
                            reg_idx_d = lowest_idx(rem_next);
                            last_d    = is_onehot(rem_next);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rem_q      <= 16'd0;
            addr_q     <= 32'd0;
            reg_idx_q  <= 4'd0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_value_q <= 32'd0;
            wb_qual_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            reg_idx_q  <= reg_idx_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            wb_en_q    <= wb_en_d;
            wb_value_q <= wb_value_d;
            wb_qual_q  <= wb_qual_d;
        end
    end

    assign addr     = addr_q;
    assign reg_idx  = reg_idx_q;
    assign valid    = valid_q;
    assign last     = last_q;
    assign busy     = (state_q == XFER);
    assign wb_en    = wb_en_q;
    assign wb_value = wb_value_q;

endmodule

// File: tb/tb_ldm_addr_seq.sv
// Directed bench for ldm_addr_seq: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed from the addressing modes.
module tb_ldm_addr_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] reglist = 16'd0;
    logic [31:0] base = 32'd0;
    logic [3:0]  rn = 4'd0;
    logic        p_bit = 1'b0;
    logic        u_bit = 1'b0;
    logic        w_bit = 1'b0;
    logic        load = 1'b0;
    logic        advance = 1'b0;
    logic        FlushE = 1'b0;
    logic [31:0] addr;
    logic [3:0]  reg_idx;
    logic        valid;
    logic        last;
    logic        busy;
    logic        wb_en;
    logic [31:0] wb_value;

    int n_checks = 0;
    int n_errors = 0;

    ldm_addr_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .reglist(reglist),
        .base(base), .rn(rn), .p_bit(p_bit), .u_bit(u_bit), .w_bit(w_bit),
        .load(load), .advance(advance), .FlushE(FlushE), .addr(addr),
        .reg_idx(reg_idx), .valid(valid), .last(last), .busy(busy),
        .wb_en(wb_en), .wb_value(wb_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_xfer(input string tag, input logic [31:0] ea, input logic [3:0] ei,
                            input logic el);
        chk({tag, " valid"}, 32'(valid), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " addr"}, addr, ea);
        chk({tag, " reg_idx"}, 32'(reg_idx), 32'(ei));
        chk({tag, " last"}, 32'(last), 32'(el));
    endtask

    task automatic chk_idle(input string tag, input logic ewb);
        chk({tag, " valid"}, 32'(valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " wb_en"}, 32'(wb_en), 32'(ewb));
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] rl, input logic [3:0] r,
                            input logic p, input logic u, input logic w, input logic ld);
        base = b; reglist = rl; rn = r; p_bit = p; u_bit = u; w_bit = w; load = ld;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst addr", addr, 32'd0);
        chk("rst reg_idx", 32'(reg_idx), 32'd0);
        chk("rst last", 32'(last), 32'd0);
        chk("rst wb_value", wb_value, 32'd0);
        chk_idle("rst", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // IA, four registers
        advance = 1'b1;
        do_start(32'h1000, 16'h00F0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_xfer("ia0", 32'h1000, 4'd4, 1'b0); @(negedge clk);
        chk_xfer("ia1", 32'h1004, 4'd5, 1'b0); @(negedge clk);
        chk_xfer("ia2", 32'h1008, 4'd6, 1'b0); @(negedge clk);
        chk_xfer("ia3", 32'h100C, 4'd7, 1'b1); @(negedge clk);
        chk_idle("ia done", 1'b1);
        chk("ia wb_value", wb_value, 32'h1010);
        @(negedge clk);
        chk("ia wb_en pulse", 32'(wb_en), 32'd0);
        chk("ia wb_value hold", wb_value, 32'h1010);

        // DB with a two-cycle stall after the first transfer
        do_start(32'h2000, 16'h8003, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_xfer("db0", 32'h1FF4, 4'd0, 1'b0); @(negedge clk);
        chk_xfer("db1", 32'h1FF8, 4'd1, 1'b0);
        advance = 1'b0;
        @(negedge clk);
        chk_xfer("db stall1", 32'h1FF8, 4'd1, 1'b0); @(negedge clk);
        chk_xfer("db stall2", 32'h1FF8, 4'd1, 1'b0);
        advance = 1'b1;
        @(negedge clk);
        chk_xfer("db2", 32'h1FFC, 4'd15, 1'b1); @(negedge clk);
        chk_idle("db done", 1'b1);
        chk("db wb_value", wb_value, 32'h1FF4);
        @(negedge clk);

        // LDM with base in list: writeback suppressed
        do_start(32'h100, 16'h0006, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_xfer("ldm0", 32'h100, 4'd1, 1'b0); @(negedge clk);
        chk_xfer("ldm1", 32'h104, 4'd2, 1'b1); @(negedge clk);
        chk_idle("ldm done", 1'b0); @(negedge clk);
        chk_idle("ldm after", 1'b0);

        // same list as STM: writeback happens
        do_start(32'h100, 16'h0006, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_xfer("stm0", 32'h100, 4'd1, 1'b0); @(negedge clk);
        chk_xfer("stm1", 32'h104, 4'd2, 1'b1); @(negedge clk);
        chk_idle("stm done", 1'b1);
        chk("stm wb_value", wb_value, 32'h108);
        @(negedge clk);

        // full list wrapping through zero
        do_start(32'hFFFF_FFF8, 16'hFFFF, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk_xfer($sformatf("wrap%0d", i), 32'hFFFF_FFF8 + 32'(4 * i), 4'(i), i == 15);
            @(negedge clk);
        end
        chk_idle("wrap done", 1'b1);
        chk("wrap wb_value", wb_value, 32'h38);
        @(negedge clk);

        // empty list is ignored
        do_start(32'h7777, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_idle("empty", 1'b0);
        chk("empty wb_value", wb_value, 32'h38);
        @(negedge clk);
        chk_idle("empty after", 1'b0);

        // flush on the second transfer of five, then an immediate restart (DA)
        do_start(32'h3000, 16'h001F, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_xfer("fl0", 32'h3000, 4'd0, 1'b0); @(negedge clk);
        chk_xfer("fl1", 32'h3004, 4'd1, 1'b0);
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        chk_idle("flushed", 1'b0);
        do_start(32'h4000, 16'h0003, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post flush wb_en", 32'(wb_en), 32'd0);
        chk_xfer("da0", 32'h3FFC, 4'd0, 1'b0); @(negedge clk);
        chk_xfer("da1", 32'h4000, 4'd1, 1'b1); @(negedge clk);
        chk_idle("da done", 1'b1);
        chk("da wb_value", wb_value, 32'h3FF8);
        @(negedge clk);

        // asynchronous reset mid-sequence
        do_start(32'h5000, 16'h00FF, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_xfer("rs1", 32'h5004, 4'd1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst addr", addr, 32'd0);
        chk("arst reg_idx", 32'(reg_idx), 32'd0);
        chk("arst last", 32'(last), 32'd0);
        chk("arst wb_value", wb_value, 32'd0);
        chk_idle("arst", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle("after rst", 1'b0);
        @(negedge clk);
        chk_idle("after rst2", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ldm_addr_seq.md
# ldm_addr_seq

Execute-stage address sequencer for load/store-multiple instructions. It sits directly downstream of the decode-stage register-list stepper. It accepts the decoded register list, base value and addressing-mode bits once per instruction, then emits one word address and register index per transfer to the memory stage. It completes by producing the base-register writeback value.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  launch a new multiple transfer; sampled only in IDLE
- reglist  in  16  register list, bit i = register i
- base  in  32  base register value (Rn)
- rn  in  4  base register index
- p_bit  in  1  1 = pre-index (before), 0 = post-index (after)
- u_bit  in  1  1 = increment, 0 = decrement
- w_bit  in  1  base writeback requested
- load  in  1  1 = LDM, 0 = STM
- advance  in  1  memory stage accepts current transfer
- FlushE  in  1  synchronous abort of the in-flight sequence
- addr  out  32  word address of current transfer
- reg_idx  out  4  register index of current transfer
- valid  out  1  addr/reg_idx meaningful
- last  out  1  current transfer is the final one
- busy  out  1  sequence in progress (state XFER)
- wb_en  out  1  one-cycle base writeback strobe
- wb_value  out  32  value to write to Rn, valid while wb_en=1

## Operation
- States: IDLE, XFER.
- Reset (async, reset_n=0) forces the following; remaining list is cleared:
  - state IDLE
  - addr=0, reg_idx=0, valid=0, last=0, busy=0
  - wb_en=0, wb_value=0
- IDLE, start=1, reglist≠0:
  - Latch reglist as remaining list.
  - Latch N = popcount(reglist), range 1..16.
  - Compute the first address:
    - IA (p=0, u=1): base
    - IB (p=1, u=1): base+4
    - DA (p=0, u=0): base−4N+4
    - DB (p=1, u=0): base−4N
  - Latch wb_value = u ? base+4N : base−4N.
  - Latch the writeback qualifier = w_bit & ~(load & reglist[rn]).
  - Go to XFER.
- IDLE, start=1, reglist=0: ignored. Stays IDLE, no outputs change, no wb_en.
- start while in XFER is ignored; upstream holds the instruction until busy drops.
- In XFER:
  - valid=1, busy=1.
  - reg_idx = lowest set bit of remaining list; addresses and registers always ascend together.
  - last=1 when exactly one bit remains.
- In XFER, advance=1 (handshake): clear the bit at reg_idx and set addr += 4.
  - If last, go to IDLE and assert wb_en next cycle if the writeback qualifier is set.
- In XFER, advance=0: hold addr, reg_idx, last unchanged.
- FlushE=1 has highest priority and applies in any state:
  - Next state IDLE, remaining list cleared, valid=0, wb_en=0.
  - A pending wb_en is cancelled.
- Arithmetic:
  - All address math is 32-bit modulo 2^32; wrap-around is silent.
  - 4N is a 7-bit value zero-extended.
- wb_en is high for exactly one cycle; wb_value holds until the next accepted start.

## Timing
- start accepted at edge t → valid=1 with first addr from t+1.
- One transfer per cycle while advance=1; an N-register list completes in N handshake cycles.
- Last handshake at edge t → busy=0, valid=0 from t+1. wb_en=1 during cycle t+1 only.
- start may be accepted at the edge ending the wb_en cycle. Minimum gap between sequences is one IDLE cycle.
- No combinational path from advance or start to any output; all outputs are registered.
- reset_n asserted mid-sequence: all outputs go to reset values immediately, with no wb_en.

## Test plan
- IA: base=0x1000, reglist=0x00F0, p=0, u=1, w=1, rn=0, advance held 1.
  - Required: addr 0x1000/0x1004/0x1008/0x100C with reg_idx 4/5/6/7.
  - Required: last on the 4th transfer; wb_en one cycle later with wb_value=0x1010.
- DB with stall: base=0x2000, reglist=0x8003, p=1, u=0, w=1, load=0.
  - Required: addr 0x1FF4/0x1FF8/0x1FFC with reg_idx 0/1/15 and wb_value=0x1FF4.
  - Drop advance for 2 cycles after the first transfer; required: addr and reg_idx hold.
- LDM with base in list: reglist=0x0006, rn=2, load=1, w=1.
  - Required: 2 transfers, wb_en never asserts.
  - Same stimulus with load=0: required wb_en asserts.
- Wrap and edge counts:
  - base=0xFFFFFFF8, IA, reglist=0xFFFF; required addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, …, 0x34; wb_value=0x38.
  - reglist=0: required no valid, no wb_en, busy stays 0.
- FlushE on the 2nd transfer of a 5-register list.
  - Required: valid=0 next cycle, no wb_en.
  - A new start the following cycle runs normally.
- reset_n pulsed low mid-sequence: required all outputs 0 asynchronously; busy=0 after release.
